// File: rtl/irrigation_zone_scheduler_pkg.sv
// Shared definitions for the irrigation zone scheduler: FSM state encoding,
// display mode codes and the zone index width used on active_zone.
package irrigation_zone_scheduler_pkg;

  // Width of a zone index; covers up to 16 zones and matches active_zone.
  localparam int ZONE_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CLOSE = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_DRIPPER   = 2'b01,
    MODE_SPLINKER  = 2'b10,
    MODE_FAULT     = 2'b11
  } mode_e;

endpackage

// File: rtl/irrigation_zone_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i+1, wrapping
// at ZONES-1 -> 0, and returns the first requesting zone index.
module rr_arbiter
  import irrigation_zone_scheduler_pkg::*;
#(
  parameter int ZONES = 4
) (
  input  logic [ZONES-1:0]      req_i,
  input  logic [ZONE_IDX_W-1:0] ptr_i,
  output logic [ZONE_IDX_W-1:0] grant_o,
  output logic                  grant_valid_o
);

  logic [ZONE_IDX_W-1:0] start;
  logic [2*ZONES-1:0]    req_dbl;
  logic [ZONES-1:0]      rot;
  logic [ZONE_IDX_W-1:0] offset;
  logic [ZONE_IDX_W:0]   sum;

  // Rotate the request vector so the search start sits at bit 0, then pick
  // the lowest set bit and rotate the index back.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    start   = (ptr_i == ZONE_IDX_W'(ZONES - 1)) ? '0 : ptr_i + 1'b1;
    req_dbl = {req_i, req_i} >> start;
    rot     = req_dbl[ZONES-1:0];
    offset  = '0;
    for (int j = ZONES - 1; j >= 0; j--) begin
      if (rot[j]) offset = ZONE_IDX_W'(j);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (ZONE_IDX_W + 1)'(ZONES)) sum = sum - (ZONE_IDX_W + 1)'(ZONES);
    grant_o       = sum[ZONE_IDX_W-1:0];
    grant_valid_o = |rot;
  end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Irrigation zone scheduler: round-robin grant of one water supply across
// ZONES zones, fixed run time, valve open/close handshake, registered
// outputs. Optional feature macro: IRRIGATION_ACK_TIMEOUT_EN adds an ack
// timeout in OPEN/CLOSE that parks the block in FAULT until irrigation_on=0.
module irrigation_zone_scheduler
  import irrigation_zone_scheduler_pkg::*;
#(
  parameter int ZONES       = 4,
  parameter int RUN_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             irrigation_on,
  input  logic [ZONES-1:0] zone_req,
  input  logic [ZONES-1:0] zone_splinker,
  input  logic             valve_ack,
  output logic [ZONES-1:0] valve_sel,
  output logic [3:0]       active_zone,
  output logic [1:0]       mode_code,
  output logic             busy
);

  localparam int CNT_W = $clog2(RUN_CYCLES + 1);

  state_e                state_q, state_d;
  logic [ZONES-1:0]      valve_sel_q, valve_sel_d;
  logic [ZONE_IDX_W-1:0] active_zone_q, active_zone_d;
  mode_e                 mode_q, mode_d;
  logic                  busy_q, busy_d;
  logic [ZONE_IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      run_cnt_q, run_cnt_d;

`ifdef IRRIGATION_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
`endif

  logic [ZONE_IDX_W-1:0] grant;
  logic                  grant_valid;
  logic [ZONES-1:0]      grant_onehot;

  rr_arbiter #(.ZONES(ZONES)) u_arb (
    .req_i         (zone_req),
    .ptr_i         (ptr_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  assign grant_onehot = ZONES'(1) << grant;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d       = state_q;
    valve_sel_d   = valve_sel_q;
    active_zone_d = active_zone_q;
    mode_d        = mode_q;
    ptr_d         = ptr_q;
    run_cnt_d     = run_cnt_q;
`ifdef IRRIGATION_ACK_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (irrigation_on && grant_valid) begin
          state_d       = ST_OPEN;
          valve_sel_d   = grant_onehot;
          active_zone_d = grant;
          mode_d        = (|(zone_splinker & grant_onehot)) ? MODE_SPLINKER : MODE_DRIPPER;
`ifdef IRRIGATION_ACK_TIMEOUT_EN
          to_cnt_d      = '0;
`endif
        end
      end
      ST_OPEN: begin
        if (!irrigation_on) begin
          state_d     = ST_CLOSE;
          valve_sel_d = '0;
`ifdef IRRIGATION_ACK_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end else if (valve_ack) begin
          state_d   = ST_RUN;
          run_cnt_d = '0;
`ifdef IRRIGATION_ACK_TIMEOUT_EN
        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          state_d     = ST_FAULT;
          valve_sel_d = '0;
          mode_d      = MODE_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        // valve_sel_q is the one-hot of the active zone while running.
        if (!irrigation_on || !(|(zone_req & valve_sel_q)) ||
            run_cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
          state_d     = ST_CLOSE;
          valve_sel_d = '0;
`ifdef IRRIGATION_ACK_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end
      ST_CLOSE: begin
        if (!valve_ack) begin
          state_d       = ST_IDLE;
          ptr_d         = active_zone_q;
          mode_d        = MODE_OFF;
          active_zone_d = '0;
`ifdef IRRIGATION_ACK_TIMEOUT_EN
        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
          mode_d  = MODE_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
`ifdef IRRIGATION_ACK_TIMEOUT_EN
      ST_FAULT: begin
        valve_sel_d = '0;
        if (!irrigation_on) begin
          state_d       = ST_IDLE;
          ptr_d         = active_zone_q;
          mode_d        = MODE_OFF;
          active_zone_d = '0;
        end
      end
`endif
      default: begin
        state_d       = ST_IDLE;
        valve_sel_d   = '0;
        active_zone_d = '0;
        mode_d        = MODE_OFF;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and output registers; reset drops the valve immediately.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      valve_sel_q   <= '0;
      active_zone_q <= '0;
      mode_q        <= MODE_OFF;
      busy_q        <= 1'b0;
      ptr_q         <= ZONE_IDX_W'(ZONES - 1);
      run_cnt_q     <= '0;
`ifdef IRRIGATION_ACK_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      valve_sel_q   <= valve_sel_d;
      active_zone_q <= active_zone_d;
      mode_q        <= mode_d;
      busy_q        <= busy_d;
      ptr_q         <= ptr_d;
      run_cnt_q     <= run_cnt_d;
`ifdef IRRIGATION_ACK_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  assign valve_sel   = valve_sel_q;
  assign active_zone = active_zone_q;
  assign mode_code   = mode_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed testbench for irrigation_zone_scheduler (ZONES=4, RUN_CYCLES=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_irrigation_zone_scheduler;

  logic       clk;
  logic       rst_n;
  logic       irrigation_on;
  logic [3:0] zone_req;
  logic [3:0] zone_splinker;
  logic       valve_ack;
  logic [3:0] valve_sel;
  logic [3:0] active_zone;
  logic [1:0] mode_code;
  logic       busy;

  int errors = 0;
  int checks = 0;

  irrigation_zone_scheduler #(
    .ZONES       (4),
    .RUN_CYCLES  (16),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irrigation_on (irrigation_on),
    .zone_req      (zone_req),
    .zone_splinker (zone_splinker),
    .valve_ack     (valve_ack),
    .valve_sel     (valve_sel),
    .active_zone   (active_zone),
    .mode_code     (mode_code),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Serve one grant from IDLE: open, run, close; ack follows valve_sel by one cycle.
  task automatic run_zone(input int z, input logic [1:0] m, input string tag);
    int run_len;
    int guard;
    tick();
    check({tag, "_sel"},  valve_sel, 32'(1) << z);
    check({tag, "_zone"}, active_zone, z);
    check({tag, "_mode"}, mode_code, m);
    check({tag, "_busy"}, busy, 1);
    valve_ack = 1'b1;
    tick();
    run_len = 1;
    guard   = 0;
    while (valve_sel != 4'b0000 && guard < 40) begin
      tick();
      guard++;
      if (valve_sel != 4'b0000) run_len++;
    end
    check({tag, "_run_len"},    run_len, 16);
    check({tag, "_close_busy"}, busy, 1);
    check({tag, "_close_mode"}, mode_code, m);
    valve_ack = 1'b0;
    tick();
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_mode"}, mode_code, 0);
    check({tag, "_idle_zone"}, active_zone, 0);
  endtask

  initial begin
    logic granted;
    rst_n = 1'b0; irrigation_on = 1'b0; zone_req = 4'b0; zone_splinker = 4'b0; valve_ack = 1'b0;

    // Reset state
    #12;
    check("rst_sel",  valve_sel, 0);
    check("rst_zone", active_zone, 0);
    check("rst_mode", mode_code, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single sprinkler zone 0, full 16-cycle run
    irrigation_on = 1'b1; zone_req = 4'b0001; zone_splinker = 4'b0001;
    run_zone(0, 2'b10, "t1");
    zone_req = 4'b0000;
    tick();
    check("t1_no_regrant", busy, 0);

    // Round robin with all zones requesting
    do_reset();
    irrigation_on = 1'b1; zone_req = 4'b1111; zone_splinker = 4'b0101;
    run_zone(0, 2'b10, "rr0");
    run_zone(1, 2'b01, "rr1");
    run_zone(2, 2'b10, "rr2");
    run_zone(3, 2'b01, "rr3");
    run_zone(0, 2'b10, "rr0b");

    // irrigation_on dropped at RUN cycle 5
    tick();
    check("t3_zone", active_zone, 1);
    valve_ack = 1'b1;
    tick();
    repeat (4) tick();
    check("t3_still_run", valve_sel, 4'b0010);
    irrigation_on = 1'b0;
    tick();
    check("t3_close_sel",  valve_sel, 0);
    check("t3_close_busy", busy, 1);
    valve_ack = 1'b0;
    tick();
    check("t3_idle_busy", busy, 0);
    granted = 1'b0;
    repeat (6) begin
      tick();
      if (valve_sel != 4'b0000 || busy) granted = 1'b1;
    end
    check("t3_no_grant_off", granted, 0);

    // Request drop and splinker toggle mid-RUN (pointer now at zone 1)
    irrigation_on = 1'b1; zone_req = 4'b0100; zone_splinker = 4'b0000;
    tick();
    check("t4_zone", active_zone, 2);
    check("t4_mode", mode_code, 2'b01);
    valve_ack = 1'b1;
    tick();
    tick();
    tick();
    zone_splinker = 4'b1111;
    tick();
    check("t4_mode_held", mode_code, 2'b01);
    check("t4_run_sel",   valve_sel, 4'b0100);
    zone_req = 4'b0000;
    tick();
    check("t4_close_sel",  valve_sel, 0);
    check("t4_close_busy", busy, 1);
    valve_ack = 1'b0;
    tick();
    check("t4_idle_busy", busy, 0);

    // Reset pulsed during RUN (pointer now at zone 2)
    zone_req = 4'b1111;
    tick();
    check("t5_zone", active_zone, 3);
    valve_ack = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_sel",  valve_sel, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_mode", mode_code, 0);
    check("t5_async_zone", active_zone, 0);
    valve_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_first_zone", active_zone, 0);
    check("t5_first_sel",  valve_sel, 4'b0001);

`ifdef IRRIGATION_ACK_TIMEOUT_EN
    // Ack never arrives in OPEN -> FAULT after 8 cycles
    irrigation_on = 1'b0; zone_req = 4'b0000;
    do_reset();
    irrigation_on = 1'b1; zone_req = 4'b0001; zone_splinker = 4'b0000; valve_ack = 1'b0;
    tick();
    repeat (7) tick();
    check("to_still_open", valve_sel, 4'b0001);
    tick();
    check("to_fault_mode", mode_code, 2'b11);
    check("to_fault_sel",  valve_sel, 0);
    check("to_fault_busy", busy, 1);
    irrigation_on = 1'b0;
    tick();
    check("to_idle_busy", busy, 0);
    check("to_idle_mode", mode_code, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
